collision_detector: RTL and testbench

COLLISION_DETECTOR -- requirements
Module: collision_detector

---
 rtl/collision_detector_pkg.sv | 13 +
 rtl/edge_decoder.sv | 26 ++
 rtl/collision_detector.sv | 103 ++++++++++
 tb/tb_collision_detector.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/collision_detector_pkg.sv
// rtl/collision_detector_pkg.sv - shared sprite geometry defaults and hit-edge bit positions
package collision_detector_pkg;
   localparam int unsigned SMILEY_SIZE_DEFAULT = 32;
   localparam int unsigned EDGE_BAND_DEFAULT   = 8;
   localparam int unsigned OFFSET_W            = 11;

   localparam int unsigned EDGE_LEFT   = 3;
   localparam int unsigned EDGE_TOP    = 2;
   localparam int unsigned EDGE_RIGHT  = 1;
   localparam int unsigned EDGE_BOTTOM = 0;

   typedef logic [3:0] edge_code_t;
endpackage

// File: rtl/edge_decoder.sv
// rtl/edge_decoder.sv - classifies a sprite-relative pixel offset into the struck edge(s)
module edge_decoder
   import collision_detector_pkg::*;
#(
   parameter int unsigned SMILEY_SIZE = SMILEY_SIZE_DEFAULT,
   parameter int unsigned EDGE_BAND   = EDGE_BAND_DEFAULT
) (
   input  logic [OFFSET_W-1:0] offset_x_i,
   input  logic [OFFSET_W-1:0] offset_y_i,
   output edge_code_t          code_o
);
   localparam logic [OFFSET_W-1:0] SIZE_W = OFFSET_W'(SMILEY_SIZE);
   localparam logic [OFFSET_W-1:0] BAND_W = OFFSET_W'(EDGE_BAND);
   localparam logic [OFFSET_W-1:0] FAR_W  = OFFSET_W'(SMILEY_SIZE - EDGE_BAND);

   // Offsets outside the sprite never classify, even if they fall in a band numerically.
   always_comb begin
      code_o = '0;
      if (offset_x_i < SIZE_W && offset_y_i < SIZE_W) begin
         code_o[EDGE_LEFT]   = offset_x_i < BAND_W;
         code_o[EDGE_RIGHT]  = offset_x_i >= FAR_W;
         code_o[EDGE_TOP]    = offset_y_i < BAND_W;
         code_o[EDGE_BOTTOM] = offset_y_i >= FAR_W;
      end
   end
endmodule

// File: rtl/collision_detector.sv
// rtl/collision_detector.sv - per-pixel sprite overlap detection with per-frame qualified obstacle hits
module collision_detector
   import collision_detector_pkg::*;
#(
   parameter int unsigned SMILEY_SIZE = SMILEY_SIZE_DEFAULT,
   parameter int unsigned EDGE_BAND   = EDGE_BAND_DEFAULT,
   parameter int unsigned MIN_OVERLAP = 2
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic                startOfFrame,
   input  logic                pause,
   input  logic                reset_level,
   input  logic                smileyDR,
   input  logic [OFFSET_W-1:0] offsetX,
   input  logic [OFFSET_W-1:0] offsetY,
   input  logic                borderTopDR,
   input  logic                borderLeftDR,
   input  logic                borderRightDR,
   input  logic                flipperDR,
   input  logic                obstacleDR,
   output logic                collisionSmileyBorderTop,
   output logic                collisionSmileyBorderLeft,
   output logic                collisionSmileyBorderRight,
   output logic                collisionSmileyFlipper,
   output logic                collisionSmileyObstacle,
   output logic [3:0]          hitEdgeCode
);
   localparam logic [7:0] MIN_W = 8'(MIN_OVERLAP);

   edge_code_t edge_code;
   logic       top_q, left_q, right_q, flip_q, sticky_q;
   logic       top_d, left_d, right_d, flip_d, sticky_d;
   logic [7:0] cnt_q, cnt_d;
   edge_code_t hit_q, hit_d;
   logic [7:0] base_cnt;
   logic       base_sticky;
   edge_code_t base_hit;

   edge_decoder #(.SMILEY_SIZE(SMILEY_SIZE), .EDGE_BAND(EDGE_BAND)) u_edge_decoder (
      .offset_x_i (offsetX),
      .offset_y_i (offsetY),
      .code_o     (edge_code)
   );

   // A frame boundary restarts accumulation but the same cycle's pixel still belongs to the new frame.
   always_comb begin
      base_cnt    = startOfFrame ? 8'd0 : cnt_q;
      base_sticky = startOfFrame ? 1'b0 : sticky_q;
      base_hit    = startOfFrame ? 4'd0 : hit_q;
      top_d       = 1'b0;
      left_d      = 1'b0;
      right_d     = 1'b0;
      flip_d      = 1'b0;
      cnt_d       = base_cnt;
      sticky_d    = base_sticky;
      hit_d       = base_hit;
      if (reset_level) begin
         cnt_d    = 8'd0;
         sticky_d = 1'b0;
         hit_d    = '0;
      end else if (!pause) begin
         top_d   = smileyDR && borderTopDR;
         left_d  = smileyDR && borderLeftDR;
         right_d = smileyDR && borderRightDR;
         flip_d  = smileyDR && flipperDR;
         if (smileyDR && obstacleDR && base_cnt < MIN_W) begin
            cnt_d = base_cnt + 8'd1;
            if (cnt_d == MIN_W && !base_sticky) begin
               sticky_d = 1'b1;
               hit_d    = edge_code;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         top_q    <= 1'b0;
         left_q   <= 1'b0;
         right_q  <= 1'b0;
         flip_q   <= 1'b0;
         cnt_q    <= 8'd0;
         sticky_q <= 1'b0;
         hit_q    <= '0;
      end else begin
         top_q    <= top_d;
         left_q   <= left_d;
         right_q  <= right_d;
         flip_q   <= flip_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         hit_q    <= hit_d;
      end
   end

   assign collisionSmileyBorderTop   = top_q;
   assign collisionSmileyBorderLeft  = left_q;
   assign collisionSmileyBorderRight = right_q;
   assign collisionSmileyFlipper     = flip_q;
   assign collisionSmileyObstacle    = sticky_q;
   assign hitEdgeCode                = hit_q;
endmodule

// File: tb/tb_collision_detector.sv
// tb/tb_collision_detector.sv - directed and random checks of collision_detector against a frame-level model
module tb_collision_detector;
   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        startOfFrame = 1'b0, pause = 1'b0, reset_level = 1'b0, smileyDR = 1'b0;
   logic [10:0] offsetX = '0, offsetY = '0;
   logic        borderTopDR = 1'b0, borderLeftDR = 1'b0, borderRightDR = 1'b0;
   logic        flipperDR = 1'b0, obstacleDR = 1'b0;
   logic        top2, left2, right2, flip2, obs2;
   logic [3:0]  code2;
   logic        top1, left1, right1, flip1, obs1;
   logic [3:0]  code1;

   int passes = 0;
   int checks = 0;

   logic [3:0] frame_hits[$];
   logic       e_top, e_left, e_right, e_flip;

   always #5 clk = ~clk;

   collision_detector #(.MIN_OVERLAP(2)) dut2 (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pause(pause),
      .reset_level(reset_level), .smileyDR(smileyDR), .offsetX(offsetX), .offsetY(offsetY),
      .borderTopDR(borderTopDR), .borderLeftDR(borderLeftDR), .borderRightDR(borderRightDR),
      .flipperDR(flipperDR), .obstacleDR(obstacleDR),
      .collisionSmileyBorderTop(top2), .collisionSmileyBorderLeft(left2),
      .collisionSmileyBorderRight(right2), .collisionSmileyFlipper(flip2),
      .collisionSmileyObstacle(obs2), .hitEdgeCode(code2));

   collision_detector #(.MIN_OVERLAP(1)) dut1 (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pause(pause),
      .reset_level(reset_level), .smileyDR(smileyDR), .offsetX(offsetX), .offsetY(offsetY),
      .borderTopDR(borderTopDR), .borderLeftDR(borderLeftDR), .borderRightDR(borderRightDR),
      .flipperDR(flipperDR), .obstacleDR(obstacleDR),
      .collisionSmileyBorderTop(top1), .collisionSmileyBorderLeft(left1),
      .collisionSmileyBorderRight(right1), .collisionSmileyFlipper(flip1),
      .collisionSmileyObstacle(obs1), .hitEdgeCode(code1));

   function automatic logic [3:0] ref_code(input int x, input int y);
      if (x >= 32 || y >= 32) return 4'b0000;
      return {x < 8, y < 8, x >= 24, y >= 24};
   endfunction

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s got=%b exp=%b", tag, got, exp);
   endtask

   task automatic check_all();
      logic [3:0] e_code2, e_code1;
      e_code2 = (frame_hits.size() >= 2) ? frame_hits[1] : 4'b0000;
      e_code1 = (frame_hits.size() >= 1) ? frame_hits[0] : 4'b0000;
      chk("top",     {3'b0, top2},   {3'b0, e_top});
      chk("left",    {3'b0, left2},  {3'b0, e_left});
      chk("right",   {3'b0, right2}, {3'b0, e_right});
      chk("flipper", {3'b0, flip2},  {3'b0, e_flip});
      chk("obs_m2",  {3'b0, obs2},   {3'b0, frame_hits.size() >= 2});
      chk("code_m2", code2, e_code2);
      chk("obs_m1",  {3'b0, obs1},   {3'b0, frame_hits.size() >= 1});
      chk("code_m1", code1, e_code1);
      chk("top_m1",  {top1, left1, right1, flip1}, {e_top, e_left, e_right, e_flip});
   endtask

   // One clock with the given inputs; the model is a per-frame list of hit-edge codes.
   task automatic cyc(input logic sof, input logic pau, input logic rl, input logic sm,
                      input int x, input int y, input logic t, input logic l,
                      input logic r, input logic f, input logic o);
      startOfFrame = sof; pause = pau; reset_level = rl; smileyDR = sm;
      offsetX = 11'(x); offsetY = 11'(y);
      borderTopDR = t; borderLeftDR = l; borderRightDR = r; flipperDR = f; obstacleDR = o;
      @(posedge clk);
      #1;
      e_top = 0; e_left = 0; e_right = 0; e_flip = 0;
      if (rl) begin
         frame_hits.delete();
      end else begin
         if (sof) frame_hits.delete();
         if (!pau) begin
            e_top = sm & t; e_left = sm & l; e_right = sm & r; e_flip = sm & f;
            if (sm && o && frame_hits.size() < 4) frame_hits.push_back(ref_code(x, y));
         end
      end
      check_all();
   endtask

   initial begin
      e_top = 0; e_left = 0; e_right = 0; e_flip = 0;
      #3;
      check_all();
      @(negedge clk);
      resetN = 1'b1;

      // Two pixels on the left band qualify with the second pixel's code.
      cyc(1,0,0, 0, 0,0,   0,0,0,0,0);
      cyc(0,0,0, 1, 3,15,  0,0,0,0,1);
      chk("req020_one_px", {3'b0, obs2}, 4'd0);
      cyc(0,0,0, 1, 4,15,  0,0,0,0,1);
      chk("req020_obs", {3'b0, obs2}, 4'd1);
      chk("req020_code", code2, 4'b1000);

      // Single pixel per frame never carries over.
      cyc(1,0,0, 1, 10,10, 0,0,0,0,1);
      cyc(1,0,0, 1, 10,10, 0,0,0,0,1);
      chk("req021_obs", {3'b0, obs2}, 4'd0);

      // Later overlaps in the frame do not modify a latched hit.
      cyc(1,0,0, 1, 30,30, 0,0,0,0,1);
      cyc(0,0,0, 1, 30,30, 0,0,0,0,1);
      cyc(0,0,0, 1, 0,15,  0,0,0,0,1);
      chk("req022_hold", code2, 4'b0011);
      cyc(1,0,0, 0, 0,0,   0,0,0,0,0);
      chk("req022_clear", code2, 4'b0000);

      // Overlaps coincident with startOfFrame belong to the new frame.
      cyc(1,0,0, 1, 16,2,  1,0,0,0,1);
      chk("req023_top", {3'b0, top1}, 4'd1);
      chk("req023_obs1", {3'b0, obs1}, 4'd1);
      chk("req023_code1", code1, 4'b0100);

      // Pause masks everything but holds a prior hit.
      cyc(0,0,0, 1, 16,2,  0,0,0,0,1);
      cyc(0,1,0, 1, 5,5,   1,1,1,1,1);
      chk("req024_obs", {3'b0, obs2}, 4'd1);
      chk("req024_border", {top2, left2, right2, flip2}, 4'd0);
      cyc(1,1,0, 1, 5,5,   1,1,1,1,1);

      // reset_level discards a partial count.
      cyc(1,0,0, 1, 12,12, 0,0,0,0,1);
      cyc(0,1,1, 0, 0,0,   0,0,0,0,0);
      cyc(0,0,0, 1, 12,12, 0,0,0,0,1);
      chk("req025_obs", {3'b0, obs2}, 4'd0);

      // Out-of-range offsets classify as interior.
      cyc(0,0,0, 1, 40,3,  0,0,0,0,1);
      chk("oob_code", code2, 4'b0000);

      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
             int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 2) == 0));
      end

      // Asynchronous reset between edges.
      #2;
      resetN = 1'b0;
      #1;
      frame_hits.delete();
      e_top = 0; e_left = 0; e_right = 0; e_flip = 0;
      check_all();
      @(negedge clk);
      resetN = 1'b1;
      cyc(0,0,0, 1, 0,31, 0,1,0,0,1);
      cyc(0,0,0, 1, 31,0, 0,0,1,1,1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
